// File: rtl/mem_bus_arbiter.sv
// rtl/mem_bus_arbiter.sv - two-master arbiter in front of a single memory bus slave
// Fair alternation when ARB_ROUND_ROBIN_EN is defined, fixed master-0 priority otherwise.
module mem_bus_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [ADDR_W-1:0]   m0_address,
  input  logic                m0_read,
  input  logic                m0_write,
  input  logic [DATA_W-1:0]   m0_writedata,
  input  logic [DATA_W/8-1:0] m0_byteenable,
  output logic                m0_waitrequest,
  output logic [DATA_W-1:0]   m0_readdata,
  input  logic [ADDR_W-1:0]   m1_address,
  input  logic                m1_read,
  input  logic                m1_write,
  input  logic [DATA_W-1:0]   m1_writedata,
  input  logic [DATA_W/8-1:0] m1_byteenable,
  output logic                m1_waitrequest,
  output logic [DATA_W-1:0]   m1_readdata,
  output logic [ADDR_W-1:0]   s_address,
  output logic                s_read,
  output logic                s_write,
  output logic [DATA_W-1:0]   s_writedata,
  output logic [DATA_W/8-1:0] s_byteenable,
  input  logic                s_waitrequest,
  input  logic [DATA_W-1:0]   s_readdata,
  output logic [1:0]          grant
);

  typedef enum logic [2:0] {IDLE, OWN0, OWN1, RD0, RD1} state_t;

  state_t state, state_nxt;
  state_t rearb0, rearb1, idle_pick;
  logic   req0, req1;

  assign req0 = m0_read | m0_write;
  assign req1 = m1_read | m1_write;

  assign m0_readdata = s_readdata;
  assign m1_readdata = s_readdata;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

`ifdef ARB_ROUND_ROBIN_EN
  // Reset to master 1 so that master 0 wins the first tie out of reset.
  logic last_owner;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                                       last_owner <= 1'b1;
    else if (state == OWN0 && req0 && !s_waitrequest) last_owner <= 1'b0;
    else if (state == OWN1 && req1 && !s_waitrequest) last_owner <= 1'b1;
  end

  always_comb begin
    rearb0    = req1 ? OWN1 : (req0 ? OWN0 : IDLE);
    rearb1    = req0 ? OWN0 : (req1 ? OWN1 : IDLE);
    idle_pick = (req0 && req1) ? (last_owner ? OWN0 : OWN1)
                               : (req0 ? OWN0 : (req1 ? OWN1 : IDLE));
  end
`else
  always_comb begin
    rearb0    = req0 ? OWN0 : (req1 ? OWN1 : IDLE);
    rearb1    = rearb0;
    idle_pick = rearb0;
  end
`endif

  always_comb begin
    state_nxt      = state;
    grant          = 2'b00;
    s_address      = '0;
    s_read         = 1'b0;
    s_write        = 1'b0;
    s_writedata    = '0;
    s_byteenable   = '0;
    m0_waitrequest = 1'b1;
    m1_waitrequest = 1'b1;
    case (state)
      IDLE: state_nxt = idle_pick;
      OWN0: begin
        grant          = 2'b01;
        s_address      = m0_address;
        s_writedata    = m0_writedata;
        s_byteenable   = m0_byteenable;
        s_write        = m0_write;
        s_read         = m0_read & ~m0_write;
        m0_waitrequest = s_waitrequest;
        if (req0 && !s_waitrequest) state_nxt = m0_write ? rearb0 : RD0;
        else if (!req0)             state_nxt = rearb0;
      end
      OWN1: begin
        grant          = 2'b10;
        s_address      = m1_address;
        s_writedata    = m1_writedata;
        s_byteenable   = m1_byteenable;
        s_write        = m1_write;
        s_read         = m1_read & ~m1_write;
        m1_waitrequest = s_waitrequest;
        if (req1 && !s_waitrequest) state_nxt = m1_write ? rearb1 : RD1;
        else if (!req1)             state_nxt = rearb1;
      end
      // Ownership is kept through the data-return cycle so the right master samples it.
      RD0: begin
        grant     = 2'b01;
        state_nxt = rearb0;
      end
      RD1: begin
        grant     = 2'b10;
        state_nxt = rearb1;
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// tb/tb_mem_bus_arbiter.sv - randomized and directed bench for mem_bus_arbiter against a behavioural model
module tb_mem_bus_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] m0_address, m1_address, m0_writedata, m1_writedata;
  logic        m0_read, m0_write, m1_read, m1_write;
  logic [3:0]  m0_byteenable, m1_byteenable;
  logic        m0_waitrequest, m1_waitrequest;
  logic [31:0] m0_readdata, m1_readdata;
  logic [31:0] s_address, s_writedata, s_readdata;
  logic        s_read, s_write, s_waitrequest;
  logic [3:0]  s_byteenable;
  logic [1:0]  grant;

  always #5 clk = ~clk;

  mem_bus_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk(clk), .reset(reset),
    .m0_address(m0_address), .m0_read(m0_read), .m0_write(m0_write),
    .m0_writedata(m0_writedata), .m0_byteenable(m0_byteenable),
    .m0_waitrequest(m0_waitrequest), .m0_readdata(m0_readdata),
    .m1_address(m1_address), .m1_read(m1_read), .m1_write(m1_write),
    .m1_writedata(m1_writedata), .m1_byteenable(m1_byteenable),
    .m1_waitrequest(m1_waitrequest), .m1_readdata(m1_readdata),
    .s_address(s_address), .s_read(s_read), .s_write(s_write),
    .s_writedata(s_writedata), .s_byteenable(s_byteenable),
    .s_waitrequest(s_waitrequest), .s_readdata(s_readdata),
    .grant(grant)
  );

  int n_vec = 0;
  int n_err = 0;

  function automatic logic [31:0] seed(int i);
    return (i == 12) ? 32'd15 : (32'hC0DE0000 | (i * 32'h111));
  endfunction

  function automatic logic [31:0] merge(logic [31:0] old, logic [31:0] nw, logic [3:0] be);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++) if (be[b]) r[8*b +: 8] = nw[8*b +: 8];
    return r;
  endfunction

  // Memory slave with one-cycle read latency.
  logic [31:0] mem [16];
  always @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < 16; i++) mem[i] <= seed(i);
      s_readdata <= '0;
    end else begin
      if (s_read && !s_waitrequest)  s_readdata <= mem[s_address[5:2]];
      if (s_write && !s_waitrequest) mem[s_address[5:2]] <= merge(mem[s_address[5:2]], s_writedata, s_byteenable);
    end
  end

  // Reference model: owner (-1 none), data-return flag, last owner, own copy of memory.
  int          own;
  bit          rd;
  logic [31:0] exp_rd;
  logic [31:0] mem_ref [16];
`ifdef ARB_ROUND_ROBIN_EN
  int          last;
`endif

  task automatic model_reset();
    own = -1;
    rd  = 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
    last = 1;
`endif
    for (int i = 0; i < 16; i++) mem_ref[i] = seed(i);
  endtask

  function automatic int pick(int p, bit r0, bit r1);
    bit rp, rq;
    rp = (p == 1) ? r1 : r0;
    rq = (p == 1) ? r0 : r1;
    return rp ? p : (rq ? 1 - p : -1);
  endfunction

  task automatic model_step();
    bit r0, r1, req, wx;
    int p, x;
    logic [3:0] idx;
    if (!reset) begin
      model_reset();
      return;
    end
    r0 = m0_read | m0_write;
    r1 = m1_read | m1_write;
`ifdef ARB_ROUND_ROBIN_EN
    p = (own < 0) ? 1 - last : 1 - own;
`else
    p = 0;
`endif
    if (own < 0) begin
      own = pick(p, r0, r1);
    end else if (rd) begin
      rd  = 1'b0;
      own = pick(p, r0, r1);
    end else begin
      x   = own;
      req = (x == 1) ? r1 : r0;
      wx  = (x == 1) ? m1_write : m0_write;
      if (req && !s_waitrequest) begin
`ifdef ARB_ROUND_ROBIN_EN
        last = x;
`endif
        idx = (x == 1) ? m1_address[5:2] : m0_address[5:2];
        if (wx) begin
          mem_ref[idx] = merge(mem_ref[idx], (x == 1) ? m1_writedata : m0_writedata,
                               (x == 1) ? m1_byteenable : m0_byteenable);
          own = pick(p, r0, r1);
        end else begin
          rd     = 1'b1;
          exp_rd = mem_ref[idx];
        end
      end else if (!req) begin
        own = pick(p, r0, r1);
      end
    end
  endtask

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_model();
    bit         act, o1;
    logic [1:0] g;
    act = (own >= 0) && !rd;
    o1  = (own == 1);
    g   = (own < 0) ? 2'b00 : (o1 ? 2'b10 : 2'b01);
    chk("grant", grant, g);
    chk("s_read", s_read, act ? (o1 ? (m1_read & ~m1_write) : (m0_read & ~m0_write)) : 1'b0);
    chk("s_write", s_write, act ? (o1 ? m1_write : m0_write) : 1'b0);
    chk("s_address", s_address, act ? (o1 ? m1_address : m0_address) : 32'd0);
    chk("s_writedata", s_writedata, act ? (o1 ? m1_writedata : m0_writedata) : 32'd0);
    chk("s_byteenable", s_byteenable, act ? (o1 ? m1_byteenable : m0_byteenable) : 4'd0);
    chk("m0_waitrequest", m0_waitrequest, (act && !o1) ? s_waitrequest : 1'b1);
    chk("m1_waitrequest", m1_waitrequest, (act && o1) ? s_waitrequest : 1'b1);
    chk("m0_readdata_bcast", m0_readdata, s_readdata);
    chk("m1_readdata_bcast", m1_readdata, s_readdata);
    if (rd) chk("read_return", o1 ? m1_readdata : m0_readdata, exp_rd);
  endtask

  task automatic to_neg();
    @(negedge clk);
    check_model();
  endtask

  task automatic edge_step();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic clear_inputs();
    m0_read = 0; m0_write = 0; m1_read = 0; m1_write = 0;
    m0_address = '0; m1_address = '0; m0_writedata = '0; m1_writedata = '0;
    m0_byteenable = 4'hF; m1_byteenable = 4'hF;
    s_waitrequest = 0;
  endtask

  task automatic go_idle();
    int n;
    clear_inputs();
    n = 0;
    while (own >= 0 && n < 8) begin
      to_neg();
      edge_step();
      n++;
    end
    if (own >= 0) chk("go_idle_timeout", 1, 0);
  endtask

  task automatic rand_inputs();
    int k;
    k = $urandom_range(0, 9);
    m0_read  = (k < 3) || (k == 9);
    m0_write = (k >= 3 && k < 6) || (k == 9);
    k = $urandom_range(0, 9);
    m1_read  = (k < 3) || (k == 9);
    m1_write = (k >= 3 && k < 6) || (k == 9);
    m0_address    = $urandom() & 32'hFFFF_FFFC;
    m1_address    = $urandom() & 32'hFFFF_FFFC;
    m0_writedata  = $urandom();
    m1_writedata  = $urandom();
    m0_byteenable = 4'($urandom_range(0, 15));
    m1_byteenable = 4'($urandom_range(0, 15));
    s_waitrequest = ($urandom_range(0, 3) == 0);
  endtask

  initial begin
    int c0, c1;
    clear_inputs();
    reset = 0;
    model_reset();

    // Reset with both masters reading, then release.
    m0_read = 1; m1_read = 1;
    repeat (2) begin
      to_neg();
      chk("rst_grant", grant, 2'b00);
      chk("rst_s_read", s_read, 1'b0);
      chk("rst_waits", {m0_waitrequest, m1_waitrequest}, 2'b11);
      edge_step();
    end
    reset = 1;
    to_neg();
    edge_step();
    to_neg();
    chk("post_rst_grant", grant, 2'b01);
    edge_step();
    go_idle();

    // Single read of memory[12].
    m0_read = 1; m0_address = 32'hBFC00030;
    to_neg();
    chk("rd_wait_first", m0_waitrequest, 1'b1);
    chk("rd_m1_wait_a", m1_waitrequest, 1'b1);
    edge_step();
    to_neg();
    chk("rd_wait_second", m0_waitrequest, 1'b0);
    chk("rd_m1_wait_b", m1_waitrequest, 1'b1);
    edge_step();
    m0_read = 0;
    to_neg();
    chk("rd_data", m0_readdata, 32'h0000000F);
    chk("rd_m1_wait_c", m1_waitrequest, 1'b1);
    edge_step();
    go_idle();

    // Slave stall during an m1 read while m0 requests.
    m1_read = 1; m1_address = 32'h0000000C;
    to_neg();
    edge_step();
    m0_read = 1; m0_address = 32'h00000004; s_waitrequest = 1;
    repeat (5) begin
      to_neg();
      chk("stall_grant", grant, 2'b10);
      edge_step();
    end
    s_waitrequest = 0;
    to_neg();
    edge_step();
    m1_read = 0;
    to_neg();
    chk("stall_rd1_grant", grant, 2'b10);
    chk("stall_rd1_m0_wait", m0_waitrequest, 1'b1);
    edge_step();
    to_neg();
    chk("stall_handover", grant, 2'b01);
    edge_step();
    go_idle();

    // Reset during the RD0 cycle, then reissue.
    m0_read = 1; m0_address = 32'h00000014;
    to_neg(); edge_step();
    to_neg(); edge_step();
    reset = 0;
    model_reset();
    to_neg();
    chk("midrst_grant", grant, 2'b00);
    chk("midrst_s_read", s_read, 1'b0);
    chk("midrst_waits", {m0_waitrequest, m1_waitrequest}, 2'b11);
    edge_step();
    reset = 1;
    to_neg(); edge_step();
    to_neg(); edge_step();
    to_neg();
    chk("midrst_reissue_data", m0_readdata, 32'hC0DE0555);
    edge_step();
    go_idle();

    // Both masters streaming writes.
    c0 = 0; c1 = 0;
    for (int n = 0; n < 9; n++) begin
      m0_write = 1; m0_writedata = 32'hAAAA0000 + n; m0_address = 32'(n * 4);
      m1_write = 1; m1_writedata = 32'h55550000 + n; m1_address = 32'(n * 4 + 32);
      to_neg();
      if (s_write && s_writedata[31:16] == 16'h5555) c1++;
      if (s_write && s_writedata[31:16] == 16'hAAAA) c0++;
      edge_step();
    end
`ifdef ARB_ROUND_ROBIN_EN
    chk("contend_m0_writes", c0, 4);
    chk("contend_m1_writes", c1, 4);
`else
    chk("prio_m0_writes", c0, 8);
    chk("prio_m1_writes", c1, 0);
`endif
    go_idle();

    // Randomized traffic with occasional asynchronous resets.
    for (int i = 0; i < 3000; i++) begin
      rand_inputs();
      if ($urandom_range(0, 199) == 0) begin
        reset = 0;
        model_reset();
      end else begin
        reset = 1;
      end
      to_neg();
      edge_step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/mem_bus_arbiter.md
# mem_bus_arbiter

Two-master arbiter sharing the single memory bus slave between `mips_cpu_bus` (master 0) and a secondary master 1, e.g. a testbench loader or DMA engine. It sits between the masters and the memory model and speaks the same read/write/waitrequest/byteenable protocol on every side. Read latency is fixed at one cycle. The arbiter holds ownership through a read's data-return cycle, so returned data cannot be claimed by the wrong master.

## Interface
Parameters:
- `ADDR_W`, 32, address width
- `DATA_W`, 32, data width; byteenable width is `DATA_W/8`

Ports:
- `clk`  in  1  system clock, rising edge
- `reset`  in  1  asynchronous, active-low reset
- `m0_address`, `m1_address`  in  ADDR_W  master addresses
- `m0_read`, `m1_read`  in  1  master read requests
- `m0_write`, `m1_write`  in  1  master write requests
- `m0_writedata`, `m1_writedata`  in  DATA_W  master write data
- `m0_byteenable`, `m1_byteenable`  in  DATA_W/8  master byte lanes
- `m0_waitrequest`, `m1_waitrequest`  out  1  stall to each master
- `m0_readdata`, `m1_readdata`  out  DATA_W  read data, broadcast of `s_readdata`
- `s_address`  out  ADDR_W  slave address
- `s_read`, `s_write`  out  1  slave commands
- `s_writedata`  out  DATA_W  slave write data
- `s_byteenable`  out  DATA_W/8  slave byte lanes
- `s_waitrequest`  in  1  slave stall
- `s_readdata`  in  DATA_W  slave read data, valid one cycle after the read is accepted
- `grant`  out  2  one-hot current owner; 00 when idle or in reset

## Operation
- A master requests when `mX_read | mX_write` is high.
- **States:** IDLE, OWN0, OWN1, RD0, RD1. State is registered; all outputs are combinational from state plus inputs.
- **IDLE:** all slave outputs are 0 and both waitrequests are 1. Next state:
  - OWNx for the winning requester.
  - If both request, the winner is master 0 after reset, otherwise the master that did not last own the bus.
- **OWNx:** master x's address, writedata and byteenable pass through to the slave.
  - `s_write = mx_write`.
  - `s_read = mx_read & ~mx_write`: write wins if both are asserted.
  - `mx_waitrequest = s_waitrequest`; the other master's waitrequest is 1.
- **Acceptance:** a command is accepted in a cycle in OWNx with request high and `s_waitrequest == 0`.
  - Accepted read → RDx.
  - Accepted write → re-arbitrate in the same edge (see below).
  - Request dropped without acceptance → re-arbitrate.
- **RDx:** slave commands are 0 and both waitrequests are 1. `s_readdata` is valid this cycle and master x samples it. The next edge re-arbitrates.
- **Re-arbitrate:**
  - If the other master is requesting → OWN(other).
  - Else if x is still requesting → OWNx.
  - Else → IDLE.
- **Last owner:** a register updated on every acceptance, used for the IDLE tie-break.
- **Inactive drive:** slave outputs in non-OWN states are driven to all zero. Address 0 is a harmless no-op on the memory.

## Timing
- **Reset values:** state IDLE, `grant` = 00, last owner = master 1 (so master 0 wins the first tie), `s_read` = `s_write` = 0, `s_address` = `s_writedata` = `s_byteenable` = 0, both waitrequests = 1.
- **Reset mid-transfer:** assertion takes effect immediately and asynchronously. An in-flight read's data is dropped. The master sees waitrequest 1 and must reissue.
- **Arbitration latency:** a request from IDLE sees waitrequest 1 for one cycle, then is forwarded.
- **Write:** minimum 2 cycles (IDLE + OWN) from idle; 1 cycle per write when the same master streams writes alone.
- **Read:** minimum 3 cycles (IDLE, OWN, RD); back-to-back reads by a lone master take 2 cycles each (OWN, RD).
- **Slave stall:** `s_waitrequest` high in OWNx holds state and ownership indefinitely. Stall is not preemptible.
- **Simultaneous events:** in one cycle where a read is accepted and the other master raises a request, the state goes to RDx first. Handover to the other master happens on the following edge.

## Configuration
- **`ARB_ROUND_ROBIN_EN` defined:** fair alternation exactly as described above.
- **`ARB_ROUND_ROBIN_EN` undefined:** fixed priority; master 0 always wins re-arbitration and IDLE ties. The last-owner register is removed, and master 1 can starve while master 0 streams.

## Test plan
- **Reset:** reset=0 for 2 cycles with both masters reading → `grant` = 00, `s_read` = 0, both waitrequests = 1. After release, `grant` = 01 on the next cycle.
- **Single read:** m0 reads address 0xBFC00030 with memory[12] = 15 → `m0_waitrequest` pattern 1, 0. `m0_readdata` = 0x0000000F in the RD0 cycle; `m1_waitrequest` = 1 throughout.
- **Contention:** both masters write continuously (m0 data 0xAAAA0000+n, m1 data 0x5555000n), with `ARB_ROUND_ROBIN_EN` defined → slave sees alternating m0/m1 writes, one per cycle after the first arbitration cycle.
- **Fixed priority:** same stimulus as contention, macro undefined → only m0 writes reach the slave; `m1_waitrequest` stays 1.
- **Slave stall:** hold `s_waitrequest` = 1 for 5 cycles during an m1 read while m0 requests → `grant` stays 10 for all 5 cycles. m0 is granted only after the RD1 cycle.
- **Reset mid-read:** assert reset in the RD0 cycle → all outputs reach reset values before the next edge. After release, m0 reissues and receives the correct data.
